pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised WIDTH-bit adder with carry-in, split into STAGES ripple chunks. Each chunk is registered, so the carry chain is broken for timing. Throughput is one addition per cycle; operands and results move over valid/ready handshakes with full backpressure. It also reports carry-out and signed overflow, and is the general-purpose arithmetic stage for datapaths wider than a single-bit adder cell.

Parameters:
WIDTH, 16, operand and sum width in bits; must be at least 2.
STAGES, 4, number of pipeline stages; must divide WIDTH exactly, with 1 <= STAGES <= WIDTH.
CHUNK, WIDTH/STAGES, bits added per stage; derived, not overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  a, b and cin carry a valid operation.
in_ready  output  1  adder accepts an operation this cycle.
a  input  WIDTH  operand A (unsigned or two's complement).
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum, cout and ovf are valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: all stage valid bits clear; all data registers zero; sum=0, cout=0, ovf=0, out_valid=0. in_ready=0 while rst=1; in_ready=1 in the first cycle after reset.
- Reset mid-operation: every in-flight result is discarded; no out_valid is produced for operations accepted before reset.
- Stage k (k=0..STAGES-1) holds a valid bit v[k] and these data fields:
  - sum bits [(k+1)*CHUNK-1:0];
  - the carry out of chunk k;
  - the unprocessed upper bits of a and b (operand skew).
- Stage k adds bits [k*CHUNK +: CHUNK] of a and b, plus the carry from stage k-1. Stage 0 uses cin as its carry.
- The last stage drives sum/cout/ovf directly from its registers. ovf is computed in the last chunk from the carry into bit WIDTH-1.
- Handshake:
  - ready[STAGES] = out_ready.
  - ready[k] = !v[k] | ready[k+1].
  - in_ready = ready[0] (combinational; no registered skid).
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - Stage k loads from stage k-1 when ready[k]. Its valid becomes v[k-1]; bubbles collapse.
  - Stage data only changes when ready[k]=1, so held outputs stay stable while out_valid=1 and out_ready=0.
- Latency: exactly STAGES cycles from input transfer to out_valid when never stalled. Throughput is 1/cycle with out_ready held high.
- Full pipeline (all v=1) with out_ready=0: in_ready=0; nothing is dropped or duplicated.
- Simultaneous input and output transfer on a full pipeline: both occur and occupancy is unchanged.
- Ordering: results leave strictly in acceptance order.
- Arithmetic wraps modulo 2^WIDTH; cout carries the lost bit.
- STAGES=1 degenerates to one registered WIDTH-bit adder with the same handshake.
- Data inputs are ignored when in_valid=0.

Decomposition:
- Shared package adder_pkg: default WIDTH/STAGES constants and a compile-time check function (WIDTH % STAGES == 0).
- One combinational sub-module, adder_chunk (parameter CHUNK): inputs a, b, cin; outputs sum, cout, and carry into its MSB (for ovf). Instantiated STAGES times in a generate loop.
- Handshake and registers stay in pipelined_adder.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=0 during rst and 1 after; no output ever appears.
- Carry across chunk boundary (WIDTH=16, STAGES=4): a=0x00FF, b=0x0001, cin=0 accepted at cycle 0 -> out_valid at cycle 4, sum=0x0100, cout=0, ovf=0.
- Full ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: stream 8 ops (a=i, b=0x1000*i), out_ready=0 on cycles 5-9:
  - in_ready=0 once 4 entries are held;
  - held sum stable while stalled;
  - all 8 results appear in order, none lost or duplicated;
  - check against a scoreboard.
- Reset mid-stream: assert rst for 1 cycle after 3 ops are accepted -> none of the 3 ever appears. A new op accepted after reset emerges STAGES cycles later with the correct result.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared defaults and configuration check for pipelined_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // True when the width/stage pair splits into equal chunks of at least one bit
    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_if
// Description : Operand/result valid-ready bundle for pipelined_adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The adder itself
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// Module      : adder_chunk
// Description : Combinational CHUNK-bit ripple adder slice with carry-in,
//               carry-out and the carry entering its most significant bit.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  wire logic [CHUNK-1:0] a,
    input  wire logic [CHUNK-1:0] b,
    input  wire logic             cin,
    output logic      [CHUNK-1:0] sum,
    output logic                  cout,
    output logic                  carry_msb
);

    logic [CHUNK:0] w_full;

    // One extra bit captures the carry out of the slice
    always_comb begin
        w_full    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum       = w_full[CHUNK-1:0];
        cout      = w_full[CHUNK];
        // sum_i = a_i ^ b_i ^ carry_i, so the carry into the MSB falls out directly
        carry_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ w_full[CHUNK-1];
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : WIDTH-bit adder with carry-in split into STAGES registered
//               ripple chunks, valid/ready on both sides with full
//               backpressure; reports carry-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input wire logic         clk,
    input wire logic         rst,
    pipelined_adder_if.slave bus
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Per-stage registers. Operands are stored pre-shifted so that the bits
    // still to be added always sit at [CHUNK-1:0] for the next stage.
    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [STAGES-1:0] r_c;
    logic              r_ovf;

    // Stage inputs (what each stage would capture) and chunk results
    logic [STAGES:0]   w_ready;
    logic [STAGES-1:0] w_src_v;
    logic [STAGES-1:0] w_src_c;
    logic [WIDTH-1:0]  w_src_a   [STAGES];
    logic [WIDTH-1:0]  w_src_b   [STAGES];
    logic [WIDTH-1:0]  w_src_sum [STAGES];
    logic [CHUNK-1:0]  w_ca      [STAGES];
    logic [CHUNK-1:0]  w_cb      [STAGES];
    logic [CHUNK-1:0]  w_csum    [STAGES];
    logic [STAGES-1:0] w_cout;
    logic [STAGES-1:0] w_cmsb;
    logic [WIDTH-1:0]  w_nsum    [STAGES];
    logic              w_unused_bits;

    // Backpressure ripples from the output toward the input; bubbles collapse
    always_comb begin
        w_ready[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready[k] = !r_v[k] || w_ready[k+1];
        end
    end

    // Select each stage's source: the input port for stage 0, else the prior stage
    always_comb begin
        w_src_v[0]   = bus.in_valid;
        w_src_c[0]   = bus.cin;
        w_src_a[0]   = bus.a;
        w_src_b[0]   = bus.b;
        w_src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k]   = r_v[k-1];
            w_src_c[k]   = r_c[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_sum[k] = r_sum[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_ca[k] = w_src_a[k][CHUNK-1:0];
            w_cb[k] = w_src_b[k][CHUNK-1:0];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a         (w_ca[k]),
            .b         (w_cb[k]),
            .cin       (w_src_c[k]),
            .sum       (w_csum[k]),
            .cout      (w_cout[k]),
            .carry_msb (w_cmsb[k])
        );
    end

    // Merge each chunk result into the partial sum carried down the pipe
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_nsum[k]                  = w_src_sum[k];
            w_nsum[k][k*CHUNK +: CHUNK] = w_csum[k];
        end
    end

    // Only the last stage's carry-into-MSB matters, and its operand registers are never consumed
    always_comb begin
        w_unused_bits = ^r_a[STAGES-1] ^ ^r_b[STAGES-1];
        for (int k = 0; k < STAGES - 1; k++) begin
            w_unused_bits = w_unused_bits ^ w_cmsb[k];
        end
    end

    // Stage registers advance only when ready; data loads only with a valid op
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_v[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_sum[k] <= w_nsum[k];
                        r_a[k]   <= w_src_a[k] >> CHUNK;
                        r_b[k]   <= w_src_b[k] >> CHUNK;
                        r_c[k]   <= w_cout[k];
                    end
                end
            end
            if (w_ready[STAGES-1] && w_src_v[STAGES-1]) begin
                r_ovf <= w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
            end
        end
    end

    // Results come straight from the last stage's registers
    always_comb begin
        bus.in_ready  = w_ready[0] && !rst;
        bus.out_valid = r_v[STAGES-1];
        bus.sum       = r_sum[STAGES-1];
        bus.cout      = r_c[STAGES-1];
        bus.ovf       = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Scoreboard testbench for pipelined_adder (WIDTH=16, STAGES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
        bit               chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t             q[$];
    int               n_pass  = 0;
    int               n_total = 0;
    int               cyc     = 0;
    bit               lat_chk_en = 1'b1;
    bit               accepted;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    logic             held_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
        exp_t            e;
        logic [WIDTH:0]  f;
        f      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.sum  = f[WIDTH-1:0];
        e.cout = f[WIDTH];
        e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
        e.acc  = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Evaluate handshakes late in the cycle, then advance to just after the next edge
    task automatic tick();
        exp_t e;
        #3;
        accepted = 1'b0;
        if (prev_stall) begin
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_sum",   {16'd0, bus.sum}, {16'd0, held_sum});
            check("hold_flags", {30'd0, bus.cout, bus.ovf}, {30'd0, held_cout, held_ovf});
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        held_sum   = bus.sum;
        held_cout  = bus.cout;
        held_ovf   = bus.ovf;
        if (bus.out_valid && bus.out_ready) begin
            check("out_expected", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sum",  {16'd0, bus.sum}, {16'd0, e.sum});
                check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
                check("ovf",  {31'd0, bus.ovf},  {31'd0, e.ovf});
                if (e.chk_lat) check("latency", cyc - e.acc, STAGES);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e         = model(bus.a, bus.b, bus.cin);
            e.acc     = cyc;
            e.chk_lat = lat_chk_en;
            q.push_back(e);
            accepted  = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int g;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        g            = 0;
        accepted     = 1'b0;
        while (!accepted && g < 20) begin
            tick();
            g++;
        end
        bus.in_valid = 1'b0;
        check("send_accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() > 0 && g < 50) begin
            tick();
            g++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int sent;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hABCD;
        bus.b         = 16'h1111;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset held with in_valid high: nothing accepted, outputs cleared
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
            check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_sum",       {16'd0, bus.sum},       32'd0);
            check("rst_flags",     {30'd0, bus.cout, bus.ovf}, 32'd0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
        repeat (6) begin
            check("no_out_after_rst", {31'd0, bus.out_valid}, 32'd0);
            tick();
        end

        // Directed arithmetic cases, one at a time, unstalled
        send(16'h00FF, 16'h0001, 1'b0); drain();
        send(16'hFFFF, 16'h0000, 1'b1); drain();
        send(16'h7FFF, 16'h0001, 1'b0); drain();
        send(16'h8000, 16'h8000, 1'b0); drain();

        // Back-to-back random stream: one result per cycle at fixed latency
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.a   = 16'($urandom);
            bus.b   = 16'($urandom);
            bus.cin = 1'($urandom);
            tick();
            check("stream_accept", {31'd0, accepted}, 32'd1);
        end
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: out_ready low on cycles 5-9 of the stream
        lat_chk_en = 1'b0;
        sent       = 0;
        for (int t = 0; t < 60 && (sent < 8 || q.size() > 0); t++) begin
            bus.out_ready = !(t >= 5 && t <= 9);
            bus.in_valid  = (sent < 8);
            bus.a         = 16'(sent);
            bus.b         = 16'(32'h1000 * sent);
            bus.cin       = 1'b0;
            #1;
            check("bp_in_ready", {31'd0, bus.in_ready},
                  {31'd0, (q.size() < STAGES) || bus.out_ready});
            tick();
            if (accepted) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_sent", sent, 8);
        check("bp_drained", q.size(), 0);

        // Reset mid-stream: three accepted ops must vanish
        lat_chk_en   = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a   = 16'(16'h0101 * (i + 1));
            bus.b   = 16'h0F0F;
            bus.cin = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        q.delete();
        prev_stall   = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (8) begin
            check("flushed", {31'd0, bus.out_valid}, 32'd0);
            tick();
        end
        send(16'h1234, 16'h4321, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
